// File: rtl/conv_enc_pkg.sv
// Shared types and helpers for the parameterised convolutional encoder.
package conv_enc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ENCODE,
      ST_FLUSH
   } state_t;

   localparam int K_MIN   = 3;
   localparam int K_LIMIT = 9;

   // Sets the top k bits of a kmax-wide left-aligned tap window.
   function automatic logic [K_LIMIT-1:0] mask_k(input logic [3:0] k, input int kmax);
      logic [K_LIMIT-1:0] m;
      m = '0;
      for (int i = 0; i < K_LIMIT; i++) begin
         if ((i < kmax) && (i >= kmax - int'(k))) m[i] = 1'b1;
      end
      return m;
   endfunction

   function automatic logic [3:0] sanitize_k(input logic [3:0] k, input int kmax);
      return ((int'(k) < K_MIN) || (int'(k) > kmax)) ? 4'(kmax) : k;
   endfunction

endpackage

// File: rtl/conv_encoder_param_if.sv
// Bit-in / symbol-out handshake bundle for conv_encoder_param.
interface conv_encoder_param_if;
   logic       in_valid;
   logic       in_ready;
   logic       in_bit;
   logic       in_last;
   logic       out_valid;
   logic       out_ready;
   logic [2:0] out_sym;
   logic [2:0] out_mask;
   logic       out_last;

   modport master (
      output in_valid, in_bit, in_last, out_ready,
      input  in_ready, out_valid, out_sym, out_mask, out_last
   );

   modport slave (
      input  in_valid, in_bit, in_last, out_ready,
      output in_ready, out_valid, out_sym, out_mask, out_last
   );
endinterface

// File: rtl/conv_enc_parity.sv
// Masked-tap XOR for a single generator polynomial.
module conv_enc_parity #(
   parameter int K_MAX = 7
) (
   input  logic [K_MAX-1:0] taps,
   input  logic [K_MAX-1:0] gen,
   input  logic [K_MAX-1:0] mask,
   output logic             parity
);

   assign parity = ^(taps & gen & mask);

endmodule

// File: rtl/conv_encoder_param.sv
// Run-time configurable convolutional encoder (K 3..K_MAX, rate 1/2 or 1/3).
// Optional puncturing to rate 2/3 when CONV_ENC_PUNCTURE_EN is defined.
module conv_encoder_param
   import conv_enc_pkg::*;
#(
   parameter int K_MAX   = 7,
   parameter int NUM_GEN = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       cfg_k,
   input  logic             cfg_rate3,
   input  logic [K_MAX-1:0] cfg_g0,
   input  logic [K_MAX-1:0] cfg_g1,
   input  logic [K_MAX-1:0] cfg_g2,
`ifdef CONV_ENC_PUNCTURE_EN
   input  logic             cfg_punct,
`endif
   conv_encoder_param_if.slave bus
);

   localparam int SR_W = K_MAX - 1;

   state_t           state;
   logic             run;
   logic [SR_W-1:0]  sr;
   logic [3:0]       flush_cnt;
   logic             phase;

   logic [3:0]       k_r;
   logic [K_MAX-1:0] g0_r, g1_r, g2_r;
   logic             rate3_r;
   logic             punct_r;

   logic             vld_p1;
   logic [2:0]       sym_p1;
   logic [2:0]       mask_p1;
   logic             last_p1;

   logic             idle;
   logic [3:0]       k_eff;
   logic [K_MAX-1:0] g0_eff, g1_eff, g2_eff;
   logic             rate3_eff;
   logic             punct_eff;
   logic             phase_eff;
   logic [SR_W-1:0]  sr_eff;
   logic             bit_eff;
   logic [K_MAX-1:0] taps;
   logic [K_MAX-1:0] mask_kv;
   logic [2:0]       parity;
   logic [2:0]       sym_mask;
   logic [2:0]       sym_next;
   logic             slot_free;
   logic             accept_in;
   logic             emit_tail;
   logic             tail_done;

   // In IDLE the live cfg inputs apply so the first bit of a frame already uses them.
   assign idle      = (state == ST_IDLE);
   assign k_eff     = idle ? sanitize_k(cfg_k, K_MAX) : k_r;
   assign g0_eff    = idle ? cfg_g0 : g0_r;
   assign g1_eff    = idle ? cfg_g1 : g1_r;
   assign g2_eff    = idle ? cfg_g2 : g2_r;
   assign rate3_eff = (NUM_GEN == 3) && (idle ? cfg_rate3 : rate3_r);
`ifdef CONV_ENC_PUNCTURE_EN
   assign punct_eff = idle ? cfg_punct : punct_r;
`else
   assign punct_eff = 1'b0;
`endif
   assign phase_eff = idle ? 1'b0 : phase;
   assign sr_eff    = idle ? '0 : sr;
   assign bit_eff   = (state == ST_FLUSH) ? 1'b0 : bus.in_bit;
   assign taps      = {bit_eff, sr_eff};
   assign mask_kv   = K_MAX'(mask_k(k_eff, K_MAX));

   conv_enc_parity #(.K_MAX(K_MAX)) u_par0 (
      .taps(taps), .gen(g0_eff), .mask(mask_kv), .parity(parity[0])
   );

   conv_enc_parity #(.K_MAX(K_MAX)) u_par1 (
      .taps(taps), .gen(g1_eff), .mask(mask_kv), .parity(parity[1])
   );

   generate
      if (NUM_GEN == 3) begin : g_gen2
         conv_enc_parity #(.K_MAX(K_MAX)) u_par2 (
            .taps(taps), .gen(g2_eff), .mask(mask_kv), .parity(parity[2])
         );
      end else begin : g_no_gen2
         assign parity[2] = 1'b0;
      end
   endgenerate

   assign sym_mask  = rate3_eff ? 3'b111 :
                      (punct_eff && phase_eff) ? 3'b001 : 3'b011;
   assign sym_next  = parity & sym_mask;

   assign slot_free = !vld_p1 || bus.out_ready;
   assign bus.in_ready = run && (state != ST_FLUSH) && slot_free;
   assign accept_in = bus.in_valid && bus.in_ready;
   assign emit_tail = (state == ST_FLUSH) && slot_free && (flush_cnt != 4'd0);
   assign tail_done = vld_p1 && bus.out_ready && last_p1;

   // Stage p1: registered output symbol, encoder state and FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         run       <= 1'b0;
         sr        <= '0;
         flush_cnt <= 4'd0;
         phase     <= 1'b0;
         vld_p1    <= 1'b0;
         sym_p1    <= 3'b000;
         mask_p1   <= 3'b000;
         last_p1   <= 1'b0;
      end else begin
         run <= 1'b1;

         if (accept_in || emit_tail) begin
            vld_p1  <= 1'b1;
            sym_p1  <= sym_next;
            mask_p1 <= sym_mask;
            last_p1 <= emit_tail && (flush_cnt == 4'd1);
            sr      <= {bit_eff, sr_eff[SR_W-1:1]};
            phase   <= !phase_eff;
         end else if (vld_p1 && bus.out_ready) begin
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
         end

         if (accept_in && bus.in_last) begin
            flush_cnt <= k_eff - 4'd1;
         end else if (emit_tail) begin
            flush_cnt <= flush_cnt - 4'd1;
         end

         case (state)
            ST_IDLE: begin
               if (accept_in) state <= bus.in_last ? ST_FLUSH : ST_ENCODE;
            end
            ST_ENCODE: begin
               if (accept_in && bus.in_last) state <= ST_FLUSH;
            end
            ST_FLUSH: begin
               if (tail_done) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Frame configuration, captured with the first accepted bit
   always_ff @(posedge clk) begin
      if (idle && accept_in) begin
         k_r     <= k_eff;
         g0_r    <= cfg_g0;
         g1_r    <= cfg_g1;
         g2_r    <= cfg_g2;
         rate3_r <= rate3_eff;
         punct_r <= punct_eff;
      end
   end

   assign bus.out_valid = vld_p1;
   assign bus.out_sym   = sym_p1;
   assign bus.out_mask  = mask_p1;
   assign bus.out_last  = last_p1;

endmodule

// File: tb/tb_conv_encoder_param.sv
// Table-driven bench for conv_encoder_param; covers puncturing when CONV_ENC_PUNCTURE_EN is defined.
module tb_conv_encoder_param;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] cfg_k;
   logic       cfg_rate3;
   logic [6:0] cfg_g0, cfg_g1, cfg_g2;
`ifdef CONV_ENC_PUNCTURE_EN
   logic       cfg_punct;
`endif

   always #5 clk = ~clk;

   conv_encoder_param_if bus ();

   conv_encoder_param #(.K_MAX(7), .NUM_GEN(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg_k     (cfg_k),
      .cfg_rate3 (cfg_rate3),
      .cfg_g0    (cfg_g0),
      .cfg_g1    (cfg_g1),
      .cfg_g2    (cfg_g2),
`ifdef CONV_ENC_PUNCTURE_EN
      .cfg_punct (cfg_punct),
`endif
      .bus       (bus)
   );

   typedef struct packed {
      logic [3:0]  k;
      logic        rate3;
      logic        punct;
      logic [6:0]  g0;
      logic [6:0]  g1;
      logic [6:0]  g2;
      logic [3:0]  nbits;
      logic [7:0]  bits;
      logic [3:0]  nsym;
      logic [23:0] sym;
      logic [23:0] msk;
      logic [3:0]  stall_at;
   } vec_t;

   vec_t vec [8];
   int   nv;
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic run_frame(input vec_t v, input int tag, input int abort_at);
      int bi, si, stalls;
      bit done, in_x, out_x;
      cfg_k     = v.k;
      cfg_rate3 = v.rate3;
      cfg_g0    = v.g0;
      cfg_g1    = v.g1;
      cfg_g2    = v.g2;
`ifdef CONV_ENC_PUNCTURE_EN
      cfg_punct = v.punct;
`endif
      bus.in_valid  = 1'b1;
      bus.in_bit    = v.bits[0];
      bus.in_last   = (v.nbits == 4'd1);
      bus.out_ready = 1'b1;
      bi = 0; si = 0; stalls = 0; done = 1'b0;
      for (int cyc = 0; cyc < 100 && !done; cyc++) begin
         if (si == abort_at) begin
            rst_n = 1'b0;
            #1;
            check($sformatf("v%0d_abort_out_valid", tag), int'(bus.out_valid), 0);
            check($sformatf("v%0d_abort_in_ready", tag), int'(bus.in_ready), 0);
            check($sformatf("v%0d_abort_out_last", tag), int'(bus.out_last), 0);
            bus.in_valid = 1'b0;
            @(posedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            return;
         end
         bus.out_ready = 1'b1;
         if (bus.out_valid && si == int'(v.stall_at) && stalls < 3) begin
            bus.out_ready = 1'b0;
            stalls++;
            #1;
            check($sformatf("v%0d_stall%0d_sym", tag, stalls), int'(bus.out_sym),
                  int'(v.sym[3*si +: 3]));
            check($sformatf("v%0d_stall%0d_in_ready", tag, stalls), int'(bus.in_ready), 0);
         end else begin
            #1;
         end
         in_x  = bus.in_valid && bus.in_ready;
         out_x = bus.out_valid && bus.out_ready;
         if (out_x) begin
            if (si < int'(v.nsym)) begin
               check($sformatf("v%0d_sym%0d", tag, si), int'(bus.out_sym), int'(v.sym[3*si +: 3]));
               check($sformatf("v%0d_mask%0d", tag, si), int'(bus.out_mask), int'(v.msk[3*si +: 3]));
               check($sformatf("v%0d_last%0d", tag, si), int'(bus.out_last),
                     (si == int'(v.nsym) - 1) ? 1 : 0);
            end
            if (bus.out_last) done = 1'b1;
            si++;
         end
         @(negedge clk);
         if (in_x) begin
            bi++;
            if (bi == 1) begin
               // Mid-frame config changes must not disturb the running frame.
               cfg_k     = 4'd5;
               cfg_rate3 = ~v.rate3;
               cfg_g0    = 7'h55;
               cfg_g1    = 7'h2A;
               cfg_g2    = 7'h33;
`ifdef CONV_ENC_PUNCTURE_EN
               cfg_punct = ~v.punct;
`endif
            end
            if (bi < int'(v.nbits)) begin
               bus.in_bit  = v.bits[bi];
               bus.in_last = (bi == int'(v.nbits) - 1);
            end else begin
               bus.in_valid = 1'b0;
               bus.in_last  = 1'b0;
            end
         end
      end
      check($sformatf("v%0d_frame_done", tag), int'(done), 1);
      check($sformatf("v%0d_frame_len", tag), si, int'(v.nsym));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec[0] = '{k: 4'd3, rate3: 1'b0, punct: 1'b0, g0: 7'b1110000, g1: 7'b1010000, g2: 7'd0,
                 nbits: 4'd4, bits: 8'b0000_1101, nsym: 4'd6,
                 sym: {3'd0, 3'd0, 3'd3, 3'd2, 3'd2, 3'd0, 3'd1, 3'd3},
                 msk: {8{3'b011}}, stall_at: 4'hF};
      vec[1] = '{k: 4'd7, rate3: 1'b1, punct: 1'b0, g0: 7'o171, g1: 7'o133, g2: 7'o165,
                 nbits: 4'd1, bits: 8'b0000_0001, nsym: 4'd7,
                 sym: {3'd0, 3'd7, 3'd2, 3'd4, 3'd3, 3'd7, 3'd5, 3'd7},
                 msk: {8{3'b111}}, stall_at: 4'hF};
      vec[2] = vec[1];
      vec[2].k = 4'd12;
      vec[3] = vec[1];
      vec[3].k = 4'd2;
      vec[4] = '{k: 4'd4, rate3: 1'b0, punct: 1'b0, g0: 7'h7F, g1: 7'b1101000, g2: 7'h7F,
                 nbits: 4'd2, bits: 8'b0000_0011, nsym: 4'd5,
                 sym: {3'd0, 3'd0, 3'd0, 3'd3, 3'd2, 3'd2, 3'd0, 3'd3},
                 msk: {8{3'b011}}, stall_at: 4'hF};
      vec[5] = vec[0];
      vec[5].stall_at = 4'd1;
      nv = 6;
`ifdef CONV_ENC_PUNCTURE_EN
      vec[6] = vec[0];
      vec[6].punct = 1'b1;
      vec[6].sym = {3'd0, 3'd0, 3'd1, 3'd2, 3'd0, 3'd0, 3'd1, 3'd3};
      vec[6].msk = {3'd0, 3'd0, 3'd1, 3'd3, 3'd1, 3'd3, 3'd1, 3'd3};
      nv = 7;
      cfg_punct = 1'b0;
`endif

      rst_n         = 1'b0;
      cfg_k         = 4'd0;
      cfg_rate3     = 1'b0;
      cfg_g0        = '0;
      cfg_g1        = '0;
      cfg_g2        = '0;
      bus.in_valid  = 1'b0;
      bus.in_bit    = 1'b0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_out_valid", int'(bus.out_valid), 0);
      check("rst_in_ready", int'(bus.in_ready), 0);
      check("rst_out_sym", int'(bus.out_sym), 0);
      check("rst_out_mask", int'(bus.out_mask), 0);
      check("rst_out_last", int'(bus.out_last), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_in_ready", int'(bus.in_ready), 1);

      for (int i = 0; i < nv; i++) run_frame(vec[i], i, -1);

      // Reset pulsed during FLUSH, then the same frame again from a clean start.
      run_frame(vec[0], 10, 4);
      run_frame(vec[0], 11, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/conv_encoder_param.md
CONV_ENCODER_PARAM -- requirements
Module: conv_encoder_param

Interface
REQ-001 Parameter K_MAX, default 7, largest supported constraint length (range 3..9).
REQ-002 Parameter NUM_GEN, default 3, number of generator polynomials implemented (2 or 3).
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 cfg_k  input  4  constraint length for the next frame; latched at frame start.
REQ-006 cfg_rate3  input  1  1 = rate 1/3 (g0,g1,g2); 0 = rate 1/2 (g0,g1); latched at frame start; ignored when NUM_GEN=2.
REQ-007 cfg_g0/cfg_g1/cfg_g2  input  K_MAX each  generator taps, left-aligned; bit K_MAX-1 multiplies the current input bit; latched at frame start.
REQ-008 in_valid / in_ready  input / output  1  input bit handshake; transfer when both are high on a rising edge.
REQ-009 in_bit  input  1  unencoded data bit.
REQ-010 in_last  input  1  marks the final data bit of the frame.
REQ-011 out_valid / out_ready  output / input  1  output symbol handshake.
REQ-012 out_sym  output  3  coded bits; [0]=g0, [1]=g1, [2]=g2.
REQ-013 out_mask  output  3  bits of out_sym that carry data; unused bits are driven 0.
REQ-014 out_last  output  1  marks the final tail symbol of the frame.

Function
REQ-015 States: IDLE, ENCODE, FLUSH.
- IDLE->ENCODE on the first accepted bit, which also latches cfg_*.
- ENCODE->FLUSH on an accepted bit with in_last=1.
- FLUSH->IDLE when the final tail symbol is accepted.
REQ-016 in_ready = (IDLE or ENCODE) and (!out_valid or out_ready); in_ready is 0 during FLUSH.
REQ-017 Latency: a bit accepted on edge n produces a registered symbol with out_valid=1 after edge n; back-to-back throughput is one symbol per cycle.
REQ-018 out_sym and out_valid hold stable while out_valid=1 and out_ready=0.
REQ-019 Shift register sr holds K_MAX-1 previous bits, most recent at the top.
- Tap vector = {in_bit, sr}.
- Generator j output = XOR of (tap vector AND cfg_gj AND mask_K), where mask_K sets the top K bits.
REQ-020 sr shifts in each consumed bit and clears to 0 at frame start.
REQ-021 FLUSH emits exactly K-1 tail symbols with input bit 0; the last carries out_last=1.
REQ-022 out_mask = 3'b011 for rate 1/2 and 3'b111 for rate 1/3.
REQ-023 cfg_k below 3 or above K_MAX is treated as K_MAX.
REQ-024 in_valid=1 with in_last=1 on the first bit of a frame is legal: one data symbol followed by K-1 tail symbols.
REQ-025 Changes to cfg_* mid-frame have no effect until the next frame.

Reset
REQ-026 While rst_n=0: state=IDLE, sr=0, flush counter=0, out_valid=0, out_sym=0, out_mask=0, out_last=0, in_ready=0; normal operation begins on the first edge after deassertion.
REQ-027 Reset asserted mid-frame aborts the frame; no out_last is produced for it.

Configuration
REQ-028 Macro CONV_ENC_PUNCTURE_EN adds input cfg_punct (1 bit, latched at frame start).
- With the macro and cfg_punct=1 in rate 1/2: symbols alternate out_mask 3'b011, 3'b001, giving rate 2/3.
- The puncture phase resets at frame start and advances on every symbol, tail symbols included.
- Without the macro: no cfg_punct port; masks follow REQ-022 only.

Structure
REQ-029 Package conv_enc_pkg holds:
- the state enum;
- the constant K_MIN=3;
- the function building mask_K from K.
REQ-030 Sub-module conv_enc_parity computes the combinational masked-tap XOR for one generator and is instantiated NUM_GEN times.

Verification
REQ-031 K=3, g0=7'b1110000, g1=7'b1010000, rate 1/2, bits 1,0,1,1 (last on 4th) -> out_sym[1:0] pairs g0g1 = 11,10,00,01,01,11, with out_last on the 6th symbol.
REQ-032 Same frame with out_ready held 0 for 3 cycles after the 2nd symbol -> symbol 10 held stable and in_ready=0 throughout; the sequence is unchanged.
REQ-033 K=7, g0=171o, g1=133o, g2=165o, rate 1/3, single bit 1 with in_last -> out_sym 3'b111 first, then 6 tail symbols, out_mask=3'b111 on all.
REQ-034 cfg_k=12 -> behaves as K=7, with 6 tail symbols.
REQ-035 rst_n pulsed low during FLUSH -> out_valid=0 immediately; the next frame matches REQ-031 exactly.
REQ-036 With CONV_ENC_PUNCTURE_EN and cfg_punct=1, the REQ-031 frame -> out_mask sequence 011,001,011,001,011,001.
